// File: rtl/interval_timer_ctrl.sv
// Sequencing controller for an N-bit interval-timer counter.
// Handles config handshake, arm/run/pause/halt and period counting.
module interval_timer_ctrl #(
    parameter int N  = 4,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [N-1:0]  cfg_limit,
    input  logic          cfg_periodic,
    input  logic          start,
    input  logic          pause,
    input  logic          halt,
    output logic [N-1:0]  count,
    output logic          tick,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] periods
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  count_q, count_d;
    logic [N-1:0]  limit_q, limit_d;
    logic          periodic_q, periodic_d;
    logic          tick_q, tick_d;
    logic [PW-1:0] periods_q, periods_d;

    logic          cfg_xfer;
    logic          at_limit;
    logic          per_sat;
    logic [PW-1:0] periods_inc;

    assign cfg_ready   = (state_q == IDLE) || (state_q == DONE);
    assign busy        = (state_q == RUN) || (state_q == PAUSED);
    assign done        = (state_q == DONE);
    assign count       = count_q;
    assign tick        = tick_q;
    assign periods     = periods_q;

    assign cfg_xfer    = cfg_valid && cfg_ready;
    assign at_limit    = (count_q == limit_q);
    assign per_sat     = (periods_q == {PW{1'b1}});
    assign periods_inc = per_sat ? periods_q : periods_q + PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            periods_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            tick_q     <= tick_d;
            periods_q  <= periods_d;
        end
    end

    // tick defaults low so it can only be a single-cycle pulse
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        tick_d     = 1'b0;
        periods_d  = periods_q;
        if (halt) begin
            state_d = IDLE;
            count_d = '0;
        end else if (cfg_xfer) begin
            state_d    = ARMED;
            count_d    = '0;
            limit_d    = cfg_limit;
            periodic_d = cfg_periodic;
            periods_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                ARMED: begin
                    if (start) state_d = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (at_limit) begin
                        tick_d    = 1'b1;
                        periods_d = periods_inc;
                        if (periodic_q) count_d = '0;
                        else            state_d = DONE;
                    end else begin
                        count_d = count_q + N'(1);
                    end
                end
                PAUSED: begin
                    if (start) state_d = RUN;
                end
                DONE: begin
                    if (start) begin
                        state_d = RUN;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl (PW=8 and PW=2 instances).
// Directed vectors push expectations; a monitor pops after each edge.
module tb_interval_timer_ctrl;

    localparam int N = 4;

    localparam int SI = 0;
    localparam int SA = 1;
    localparam int SR = 2;
    localparam int SD = 3;

    typedef struct {
        int c;
        bit t;
        bit b;
        bit d;
        bit r;
        int p;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         cfg_valid;
    logic [N-1:0] cfg_limit;
    logic         cfg_periodic;
    logic         start;
    logic         pause;
    logic         halt;

    logic         cfg_ready, tick, busy, done;
    logic [N-1:0] count;
    logic [7:0]   periods;

    logic         cfg_ready2, tick2, busy2, done2;
    logic [N-1:0] count2;
    logic [1:0]   periods2;

    exp_t q[$];
    int   checks;
    int   errors;

    interval_timer_ctrl #(.N(N), .PW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_limit(cfg_limit), .cfg_periodic(cfg_periodic),
        .start(start), .pause(pause), .halt(halt),
        .count(count), .tick(tick), .busy(busy), .done(done),
        .periods(periods)
    );

    interval_timer_ctrl #(.N(N), .PW(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
        .cfg_limit(cfg_limit), .cfg_periodic(cfg_periodic),
        .start(start), .pause(pause), .halt(halt),
        .count(count2), .tick(tick2), .busy(busy2), .done(done2),
        .periods(periods2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("count", int'(count), e.c);
            chk("tick", int'(tick), int'(e.t));
            chk("busy", int'(busy), int'(e.b));
            chk("done", int'(done), int'(e.d));
            chk("cfg_ready", int'(cfg_ready), int'(e.r));
            chk("periods", int'(periods), e.p);
            chk("periods_sat", int'(periods2), (e.p > 3) ? 3 : e.p);
            chk("count_pw2", int'(count2), e.c);
        end
    end

    task automatic idle_in();
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        halt      = 1'b0;
    endtask

    // push the expected result of the coming edge, then advance
    task automatic cyc(input int c, input bit t, input int s, input int p);
        exp_t e;
        e.c = c;
        e.t = t;
        e.b = (s == SR);
        e.d = (s == SD);
        e.r = (s == SI) || (s == SD);
        e.p = p;
        q.push_back(e);
        @(negedge clk);
        idle_in();
    endtask

    task automatic cfg(input int lim, input bit per);
        cfg_valid    = 1'b1;
        cfg_limit    = N'(lim);
        cfg_periodic = per;
        cyc(0, 0, SA, 0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cfg_limit    = '0;
        cfg_periodic = 1'b0;
        idle_in();
        rst_n = 1'b0;
        @(negedge clk);

        // reset state
        rst_n = 1'b0; cyc(0, 0, SI, 0);

        // reset mid-run
        cfg(9, 0);
        start = 1'b1; cyc(0, 0, SR, 0);
        for (int i = 1; i <= 5; i++) cyc(i, 0, SR, 0);
        rst_n = 1'b0; cyc(0, 0, SI, 0);

        // one-shot L=5, restart from DONE, then halt keeps periods
        cfg(5, 0);
        start = 1'b1; cyc(0, 0, SR, 0);
        for (int i = 1; i <= 5; i++) cyc(i, 0, SR, 0);
        cyc(5, 1, SD, 1);
        cyc(5, 0, SD, 1);
        start = 1'b1; cyc(0, 0, SR, 1);
        halt = 1'b1; cyc(0, 0, SI, 1);

        // periodic L=3, pause ignored in ARMED, cfg ignored in RUN
        cfg(3, 1);
        pause = 1'b1; cyc(0, 0, SA, 0);
        start = 1'b1; cyc(0, 0, SR, 0);
        for (int i = 1; i <= 20; i++) begin
            if (i == 6) begin
                cfg_valid    = 1'b1;
                cfg_limit    = N'(7);
                cfg_periodic = 1'b0;
            end
            cyc(i % 4, (i % 4) == 0, SR, i / 4);
        end
        halt = 1'b1; cyc(0, 0, SI, 5);

        // pause/resume L=7 one-shot
        cfg(7, 0);
        start = 1'b1; cyc(0, 0, SR, 0);
        for (int i = 1; i <= 4; i++) cyc(i, 0, SR, 0);
        for (int i = 0; i < 3; i++) begin
            pause = 1'b1; cyc(4, 0, SR, 0);
        end
        cyc(4, 0, SR, 0);
        start = 1'b1; cyc(4, 0, SR, 0);
        for (int i = 5; i <= 7; i++) cyc(i, 0, SR, 0);
        cyc(7, 1, SD, 1);

        // halt exactly at terminal count
        cfg(2, 1);
        start = 1'b1; cyc(0, 0, SR, 0);
        cyc(1, 0, SR, 0);
        cyc(2, 0, SR, 0);
        halt = 1'b1; cyc(0, 0, SI, 0);
        cyc(0, 0, SI, 0);

        // L=0 periodic
        cfg(0, 1);
        start = 1'b1; cyc(0, 0, SR, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, SR, i);
        halt = 1'b1; cyc(0, 0, SI, 4);

        // L=15 one-shot, no wrap
        cfg(15, 0);
        start = 1'b1; cyc(0, 0, SR, 0);
        for (int i = 1; i <= 15; i++) cyc(i, 0, SR, 0);
        cyc(15, 1, SD, 1);
        cyc(15, 0, SD, 1);

        // config accepted from DONE clears periods
        cfg(1, 1);
        rst_n = 1'b0; cyc(0, 0, SI, 0);

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
Sequencing controller for an N-bit up-counter datapath used as an interval timer. Accepts a terminal-count configuration through a valid/ready handshake, then arms, runs, pauses, and stops the count. Flags terminal count in either one-shot or periodic mode, and keeps a saturating count of completed periods. Sits between a host/config sequencer and the counter, and provides the timing tick for downstream blocks.

Parameters:
N, 4, width of the counter and of the terminal-count limit
PW, 8, width of the completed-period counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
cfg_valid  input  1  configuration offered
cfg_ready  output  1  controller can accept configuration
cfg_limit  input  N  terminal count value
cfg_periodic  input  1  1 = periodic (auto-reload), 0 = one-shot
start  input  1  begin or resume counting
pause  input  1  freeze count while in RUN
halt  input  1  abort; return to IDLE
count  output  N  current counter value
tick  output  1  one-cycle pulse, registered, on terminal count
busy  output  1  high in RUN or PAUSED
done  output  1  high in DONE (one-shot completed)
periods  output  PW  number of completed periods, saturating

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at an edge): state=IDLE, count=0, tick=0, periods=0, limit=0, periodic=0. Reset overrides all other inputs, including mid-run.
- States: IDLE, ARMED, RUN, PAUSED, DONE. busy=(RUN|PAUSED); done=(DONE); cfg_ready=(IDLE|DONE), combinational from state.
- Priority at every edge: rst_n > halt > cfg handshake > start > pause > counting.
- halt in any non-IDLE state: next state IDLE, count=0, tick=0. periods and the latched config are held.
- Config handshake: transfer occurs when cfg_valid & cfg_ready at the edge. It latches limit and periodic, clears count and periods, and sets the next state to ARMED. cfg_valid in other states is ignored and not queued.
- ARMED: start -> RUN; count stays 0. pause is ignored.
- RUN, no pause, count!=limit: count<=count+1, wrapping modulo 2^N (unreachable since count<=limit, but required).
- RUN, count==limit:
  - tick<=1 for exactly the next cycle.
  - periods<=periods+1, saturating at 2^PW-1.
  - Periodic mode: count<=0 and state stays RUN.
  - One-shot mode: count holds limit and state<=DONE.
- RUN with pause=1 (and no halt): state<=PAUSED, count holds, no terminal check that edge.
- PAUSED: count holds. start -> RUN; counting resumes on the following edge. pause is level-insensitive there.
- DONE: count holds limit. start -> RUN with count<=0 and periods kept. A config transfer -> ARMED.
- limit=0: the terminal fires at the first RUN edge. In periodic mode, tick=1 every cycle from the second RUN cycle on.
- Period length: for limit L in periodic mode, the spacing between tick pulses is L+1 cycles.
- tick is 0 in every cycle not directly following a terminal edge.
- Latency: start sampled at edge k -> state RUN after edge k, and count=1 after edge k+1.

Test Plan:
- Reset mid-run: N=4, L=9, run 5 cycles, assert rst_n=0 for 1 edge -> count=0, state IDLE, tick=0, periods=0, cfg_ready=1.
- One-shot: cfg L=5, periodic=0, start -> count 0,1,2,3,4,5; tick=1 for one cycle; done=1; count holds 5; periods=1; busy=0.
- Periodic: L=3, start, run 20 cycles -> ticks exactly 4 cycles apart; count sequence 0,1,2,3,0...; periods increments per tick; done never 1.
- Pause/resume: L=7, pause at count=4 for 3 cycles -> count stays 4, busy=1. start -> count continues 5,6,7, then tick. Total tick delay from start = 8 run cycles + 3 paused cycles + resume latency.
- Halt vs terminal and config gating: at count==L assert halt -> state IDLE, no tick, periods unchanged. Assert cfg_valid while RUN -> cfg_ready=0, no latch.
- Edge limits: L=0 periodic -> tick every cycle after the first. L=15 (N=4) one-shot -> reaches 15 with no wrap, then DONE. Use PW=2 with a 5-period run -> periods saturates at 3.
